// File: rtl/e203_exu_flush_sched.sv
// Commit-side flush scheduler: arbitrates lp/ex/bj flush requests and WFI halt
// onto a single IFU flush channel plus the IFU/EXU halt handshakes.
module e203_exu_flush_sched #(
  parameter int unsigned PC_W        = 32,
  parameter int unsigned CNT_W       = 16,
  parameter int unsigned ACK_TIMEOUT = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             lp_req_valid,
  input  logic [PC_W-1:0]  lp_req_pc,
  output logic             lp_req_ready,
  input  logic             ex_req_valid,
  input  logic [PC_W-1:0]  ex_req_pc,
  output logic             ex_req_ready,
  input  logic             bj_req_valid,
  input  logic [PC_W-1:0]  bj_req_pc,
  output logic             bj_req_ready,
  input  logic             wfi_req_valid,
  output logic             wfi_req_ready,
  input  logic             wakeup,
  output logic             pipe_flush_req,
  output logic [PC_W-1:0]  pipe_flush_pc,
  input  logic             pipe_flush_ack,
  output logic             halt_ifu_req,
  input  logic             halt_ifu_ack,
  output logic             halt_exu_req,
  input  logic             halt_exu_ack,
  output logic             wfi_sleeping,
  output logic [CNT_W-1:0] flush_cnt,
  output logic             ack_timeout
);

  localparam int unsigned TO_W = (ACK_TIMEOUT > 0) ? $clog2(ACK_TIMEOUT + 1) : 1;
  localparam logic [TO_W-1:0] TO_LIM = TO_W'(ACK_TIMEOUT);

  typedef enum logic [1:0] {IDLE, FLUSH, HALT, SLEEP} state_t;

  state_t            state_q, state_d;
  logic              grant_lp, grant_ex, grant_bj, grant_wfi, flush_grant;
  logic [PC_W-1:0]   grant_pc;
  logic [PC_W-1:0]   flush_pc_q;
  logic [CNT_W-1:0]  flush_cnt_q;
  logic              ifu_flag_q, exu_flag_q;
  logic              halt_done;
  logic              waiting;
  logic [TO_W-1:0]   to_cnt_q;
  logic              ack_timeout_q;

  // Fixed priority grant; nothing is granted while rst is high so that a
  // request presented during reset is not captured.
  always_comb begin
    grant_lp  = 1'b0;
    grant_ex  = 1'b0;
    grant_bj  = 1'b0;
    grant_wfi = 1'b0;
    grant_pc  = '0;
    if (state_q == IDLE && !rst) begin
      if (lp_req_valid) begin
        grant_lp = 1'b1;
        grant_pc = lp_req_pc;
      end else if (ex_req_valid) begin
        grant_ex = 1'b1;
        grant_pc = ex_req_pc;
      end else if (bj_req_valid) begin
        grant_bj = 1'b1;
        grant_pc = bj_req_pc;
      end else if (wfi_req_valid) begin
        grant_wfi = 1'b1;
      end
    end
  end

  assign flush_grant = grant_lp | grant_ex | grant_bj;
  assign halt_done   = (ifu_flag_q | halt_ifu_ack) & (exu_flag_q | halt_exu_ack);
  assign waiting     = (state_q == FLUSH) || (state_q == HALT);

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (flush_grant)    state_d = FLUSH;
        else if (grant_wfi) state_d = HALT;
      end
      FLUSH: if (pipe_flush_ack) state_d = IDLE;
      HALT: begin
        if (wakeup)         state_d = IDLE;
        else if (halt_done) state_d = SLEEP;
      end
      SLEEP: if (wakeup) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      flush_pc_q    <= '0;
      flush_cnt_q   <= '0;
      ifu_flag_q    <= 1'b0;
      exu_flag_q    <= 1'b0;
      to_cnt_q      <= '0;
      ack_timeout_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (flush_grant) flush_pc_q <= grant_pc;
      if (state_q == FLUSH && pipe_flush_ack && flush_cnt_q != '1)
        flush_cnt_q <= flush_cnt_q + 1'b1;
      // Flags live only while halted; any exit (abort or wakeup) clears them.
      ifu_flag_q <= (state_d == HALT || state_d == SLEEP) &&
                    (ifu_flag_q || (state_q == HALT && halt_ifu_ack));
      exu_flag_q <= (state_d == HALT || state_d == SLEEP) &&
                    (exu_flag_q || (state_q == HALT && halt_exu_ack));
      if (waiting) begin
        if (to_cnt_q != TO_LIM) to_cnt_q <= to_cnt_q + 1'b1;
        if (ACK_TIMEOUT != 0 && (to_cnt_q + 1'b1) == TO_LIM) ack_timeout_q <= 1'b1;
      end else begin
        to_cnt_q <= '0;
      end
    end
  end

  assign lp_req_ready   = grant_lp;
  assign ex_req_ready   = grant_ex;
  assign bj_req_ready   = grant_bj;
  assign wfi_req_ready  = grant_wfi;
  assign pipe_flush_req = (state_q == FLUSH);
  assign pipe_flush_pc  = flush_pc_q;
  assign halt_ifu_req   = (state_q == HALT) || (state_q == SLEEP);
  assign halt_exu_req   = (state_q == HALT) || (state_q == SLEEP);
  assign wfi_sleeping   = (state_q == SLEEP);
  assign flush_cnt      = flush_cnt_q;
  assign ack_timeout    = ack_timeout_q;

endmodule

// File: tb/tb_e203_exu_flush_sched.sv
// Directed bench: two scheduler instances share stimulus; dut_a uses default
// parameters, dut_b uses CNT_W=2 / ACK_TIMEOUT=4 for saturation and timeout.
module tb_e203_exu_flush_sched;

  logic        clk = 1'b0;
  logic        rst;
  logic        lp_req_valid, ex_req_valid, bj_req_valid, wfi_req_valid;
  logic [31:0] lp_req_pc, ex_req_pc, bj_req_pc;
  logic        wakeup, pipe_flush_ack, halt_ifu_ack, halt_exu_ack;

  logic        a_lp_rdy, a_ex_rdy, a_bj_rdy, a_wfi_rdy, a_req, a_hi, a_he, a_sl, a_to;
  logic [31:0] a_pc;
  logic [15:0] a_cnt;
  logic        b_lp_rdy, b_ex_rdy, b_bj_rdy, b_wfi_rdy, b_req, b_hi, b_he, b_sl, b_to;
  logic [31:0] b_pc;
  logic [1:0]  b_cnt;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  e203_exu_flush_sched dut_a (
    .clk(clk), .rst(rst),
    .lp_req_valid(lp_req_valid), .lp_req_pc(lp_req_pc), .lp_req_ready(a_lp_rdy),
    .ex_req_valid(ex_req_valid), .ex_req_pc(ex_req_pc), .ex_req_ready(a_ex_rdy),
    .bj_req_valid(bj_req_valid), .bj_req_pc(bj_req_pc), .bj_req_ready(a_bj_rdy),
    .wfi_req_valid(wfi_req_valid), .wfi_req_ready(a_wfi_rdy), .wakeup(wakeup),
    .pipe_flush_req(a_req), .pipe_flush_pc(a_pc), .pipe_flush_ack(pipe_flush_ack),
    .halt_ifu_req(a_hi), .halt_ifu_ack(halt_ifu_ack),
    .halt_exu_req(a_he), .halt_exu_ack(halt_exu_ack),
    .wfi_sleeping(a_sl), .flush_cnt(a_cnt), .ack_timeout(a_to)
  );

  e203_exu_flush_sched #(.PC_W(32), .CNT_W(2), .ACK_TIMEOUT(4)) dut_b (
    .clk(clk), .rst(rst),
    .lp_req_valid(lp_req_valid), .lp_req_pc(lp_req_pc), .lp_req_ready(b_lp_rdy),
    .ex_req_valid(ex_req_valid), .ex_req_pc(ex_req_pc), .ex_req_ready(b_ex_rdy),
    .bj_req_valid(bj_req_valid), .bj_req_pc(bj_req_pc), .bj_req_ready(b_bj_rdy),
    .wfi_req_valid(wfi_req_valid), .wfi_req_ready(b_wfi_rdy), .wakeup(wakeup),
    .pipe_flush_req(b_req), .pipe_flush_pc(b_pc), .pipe_flush_ack(pipe_flush_ack),
    .halt_ifu_req(b_hi), .halt_ifu_ack(halt_ifu_ack),
    .halt_exu_req(b_he), .halt_exu_ack(halt_exu_ack),
    .wfi_sleeping(b_sl), .flush_cnt(b_cnt), .ack_timeout(b_to)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  // readies {lp,ex,bj,wfi} of both instances
  task automatic chk_rdy(input string tag, input logic [3:0] exp);
    #1;
    chk(tag, {24'd0, a_lp_rdy, a_ex_rdy, a_bj_rdy, a_wfi_rdy,
                     b_lp_rdy, b_ex_rdy, b_bj_rdy, b_wfi_rdy}, {24'd0, exp, exp});
  endtask

  // {pipe_flush_req, halt_ifu_req, halt_exu_req, wfi_sleeping} of both instances
  task automatic chk_st(input string tag, input logic [3:0] exp);
    chk(tag, {24'd0, a_req, a_hi, a_he, a_sl, b_req, b_hi, b_he, b_sl}, {24'd0, exp, exp});
  endtask

  task automatic chk_pc(input string tag, input logic [31:0] exp);
    chk({tag, "_a"}, a_pc, exp);
    chk({tag, "_b"}, b_pc, exp);
  endtask

  initial begin
    rst = 1'b1;
    {lp_req_valid, ex_req_valid, bj_req_valid, wfi_req_valid} = '0;
    lp_req_pc = '0; ex_req_pc = '0; bj_req_pc = '0;
    {wakeup, pipe_flush_ack, halt_ifu_ack, halt_exu_ack} = '0;
    step(); step();
    rst = 1'b0;
    chk_st("rst_st", 4'b0000);
    chk_pc("rst_pc", 32'h0);
    chk("rst_cnt", {a_cnt, 14'd0, b_cnt}, 32'h0);
    chk("rst_to", {30'd0, a_to, b_to}, 32'h0);
    chk_rdy("rst_rdy", 4'b0000);

    // Priority: lp > ex > bj, one grant every 2 cycles
    lp_req_valid = 1; lp_req_pc = 32'h100;
    ex_req_valid = 1; ex_req_pc = 32'h200;
    bj_req_valid = 1; bj_req_pc = 32'h300;
    chk_rdy("pri_rdy_lp", 4'b1000);
    step();
    lp_req_valid = 0;
    chk_st("pri_fl1", 4'b1000);
    chk_pc("pri_pc1", 32'h100);
    pipe_flush_ack = 1;
    chk_rdy("pri_rdy_fl1", 4'b0000);
    step();
    pipe_flush_ack = 0;
    chk_st("pri_idle1", 4'b0000);
    chk("pri_cnt1", {a_cnt, 14'd0, b_cnt}, {16'd1, 16'd1});
    chk_rdy("pri_rdy_ex", 4'b0100);
    step();
    ex_req_valid = 0;
    chk_st("pri_fl2", 4'b1000);
    chk_pc("pri_pc2", 32'h200);
    pipe_flush_ack = 1;
    step();
    pipe_flush_ack = 0;
    chk_rdy("pri_rdy_bj", 4'b0010);
    step();
    bj_req_valid = 0;
    chk_pc("pri_pc3", 32'h300);
    pipe_flush_ack = 1;
    step();
    pipe_flush_ack = 0;
    chk_st("pri_idle3", 4'b0000);
    chk("pri_cnt3", {a_cnt, 14'd0, b_cnt}, {16'd3, 16'd3});
    chk_pc("pri_pc_keep", 32'h300);

    // Held ack: 10 FLUSH cycles without ack, other requesters held off
    bj_req_valid = 1; bj_req_pc = 32'h8000_0004;
    chk_rdy("held_rdy_bj", 4'b0010);
    step();
    bj_req_valid = 0;
    lp_req_valid = 1; lp_req_pc = 32'h999; wfi_req_valid = 1;
    for (int i = 0; i < 10; i++) begin
      chk_st("held_st", 4'b1000);
      chk_pc("held_pc", 32'h8000_0004);
      chk_rdy("held_rdy", 4'b0000);
      chk("held_to", {30'd0, a_to, b_to}, {30'd0, 1'b0, (i >= 4)});
      step();
    end
    pipe_flush_ack = 1;
    chk_st("held_ackcyc", 4'b1000);
    step();
    pipe_flush_ack = 0;
    chk_st("held_done", 4'b0000);
    chk_rdy("held_rdy_after", 4'b1000);
    lp_req_valid = 0; wfi_req_valid = 0;
    chk("held_cnt", {a_cnt, 14'd0, b_cnt}, {16'd4, 16'd3});
    chk("held_to_sticky", {30'd0, a_to, b_to}, 32'd1);

    // WFI: ifu ack at +2, exu ack at +5, sleep at +6, wakeup at +9
    wfi_req_valid = 1;
    chk_rdy("wfi_rdy", 4'b0001);
    step();                                   // +1
    wfi_req_valid = 0;
    ex_req_valid = 1; ex_req_pc = 32'h4000;
    chk_st("wfi_halt1", 4'b0110);
    chk_rdy("wfi_rdy_halt", 4'b0000);
    step();                                   // +2
    halt_ifu_ack = 1;
    step();                                   // +3
    halt_ifu_ack = 0;
    chk_st("wfi_halt3", 4'b0110);
    step(); step();                           // +5
    halt_exu_ack = 1;
    chk_st("wfi_halt5", 4'b0110);
    step();                                   // +6
    halt_exu_ack = 0;
    chk_st("wfi_sleep6", 4'b0111);
    chk_rdy("wfi_rdy_sleep", 4'b0000);
    step(); step(); step();                   // +9
    wakeup = 1;
    chk_st("wfi_sleep9", 4'b0111);
    step();                                   // +10
    wakeup = 0;
    chk_st("wfi_wake10", 4'b0000);
    chk_rdy("wfi_rdy_ex10", 4'b0100);
    step();
    ex_req_valid = 0;
    chk_pc("wfi_expc", 32'h4000);
    pipe_flush_ack = 1;
    step();
    pipe_flush_ack = 0;
    chk("sat_cnt", {a_cnt, 14'd0, b_cnt}, {16'd5, 16'd3});

    // WFI abort: wakeup with both acks in the same HALT cycle wins
    wfi_req_valid = 1;
    chk_rdy("abt_rdy", 4'b0001);
    step();
    wfi_req_valid = 0;
    wakeup = 1; halt_ifu_ack = 1; halt_exu_ack = 1;
    chk_st("abt_halt", 4'b0110);
    step();
    wakeup = 0; halt_ifu_ack = 0; halt_exu_ack = 0;
    chk_st("abt_idle", 4'b0000);
    // acks in IDLE ignored, and no stale flags carried into the next halt
    pipe_flush_ack = 1;
    step();
    pipe_flush_ack = 0;
    chk("ign_cnt", {a_cnt, 14'd0, b_cnt}, {16'd5, 16'd3});
    chk_st("ign_st", 4'b0000);
    wfi_req_valid = 1;
    step();
    wfi_req_valid = 0;
    step();
    chk_st("noflag_halt", 4'b0110);
    halt_ifu_ack = 1; halt_exu_ack = 1;
    step();
    halt_ifu_ack = 0; halt_exu_ack = 0;
    chk_st("both_sleep", 4'b0111);
    wakeup = 1;
    step();
    wakeup = 0;
    chk_st("both_wake", 4'b0000);

    // Reset in the middle of a flush
    bj_req_valid = 1; bj_req_pc = 32'h1234;
    step();
    bj_req_valid = 0;
    chk_st("mid_fl", 4'b1000);
    rst = 1;
    step(); step();
    rst = 0;
    chk_st("mid_rst_st", 4'b0000);
    chk_pc("mid_rst_pc", 32'h0);
    chk("mid_rst_cnt", {a_cnt, 14'd0, b_cnt}, 32'h0);
    chk("mid_rst_to", {30'd0, a_to, b_to}, 32'h0);
    lp_req_valid = 1; lp_req_pc = 32'h55;
    chk_rdy("post_rdy", 4'b1000);
    step();
    lp_req_valid = 0;
    pipe_flush_ack = 1;
    step();
    pipe_flush_ack = 0;
    chk("post_cnt", {a_cnt, 14'd0, b_cnt}, {16'd1, 16'd1});
    chk_pc("post_pc", 32'h55);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
